// File: rtl/ari_dispatch_queue_pkg.sv
// Shared parameters and the back-end vector uop type used by the arithmetic dispatch queue.
package ari_dispatch_queue_pkg;

  localparam int DEF_NUM_OF_ARI_ISSUE = 2;
  localparam int DEF_ARI_QUEUE_DEPTH  = 8;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [15:0] tag;
  } vuop_back_t;

endpackage

// File: rtl/ari_dispatch_queue.sv
// In-order circular dispatch queue feeding up to NUM_OF_ARI_ISSUE arithmetic lanes per cycle.
// Lanes are combinational views of head..head+N-1; flush and reset empty the queue in one cycle.
module ari_dispatch_queue
  import ari_dispatch_queue_pkg::*;
#(
  parameter int NUM_OF_ARI_ISSUE = DEF_NUM_OF_ARI_ISSUE,
  parameter int ARI_QUEUE_DEPTH  = DEF_ARI_QUEUE_DEPTH
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  input  vuop_back_t                          in_op,
  output logic                                in_ready,
  output vuop_back_t [NUM_OF_ARI_ISSUE-1:0]   op_out,
  output logic [NUM_OF_ARI_ISSUE-1:0]         op_valid_out,
  input  logic                                stall_in,
  input  logic                                flush_in,
  output logic [$clog2(ARI_QUEUE_DEPTH):0]    count_out
);

  localparam int PW = $clog2(ARI_QUEUE_DEPTH);
  localparam int CW = PW + 1;

  vuop_back_t     mem [ARI_QUEUE_DEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count;
  logic [CW-1:0]  n_issue;
  logic           enq;

  assign in_ready  = (count < CW'(ARI_QUEUE_DEPTH));
  assign count_out = count;
  assign enq       = in_valid && in_ready && !flush_in;

  // Issue width is limited by occupancy; an entry written this cycle is not yet counted.
  always_comb begin
    n_issue = '0;
    if (!stall_in && !flush_in) begin
      n_issue = (count < CW'(NUM_OF_ARI_ISSUE)) ? count : CW'(NUM_OF_ARI_ISSUE);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OF_ARI_ISSUE; i++) begin
      op_valid_out[i] = (CW'(i) < count) && !flush_in;
      op_out[i]       = op_valid_out[i] ? mem[head + PW'(i)] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_issue[PW-1:0];
      if (enq) begin
        tail <= tail + PW'(1);
      end
      count <= count + CW'(enq) - n_issue;
    end
  end

  // Storage is not cleared on reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (enq && !reset) begin
      mem[tail] <= in_op;
    end
  end

endmodule
